// File: rtl/tb_pkg.sv
// tb_pkg: shared state type and constants for the memory responder (LFSR constants serve TB_RANDOM_WAIT_EN)
package tb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} port_state_t;
  localparam logic [63:0] DEFAULT_CTRL_ADDR = '1;
  localparam logic [63:0] EXIT_PASS = '0;
  localparam logic [63:0] EXIT_TIMEOUT = '1;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? (s >> 1) ^ LFSR_TAPS : s >> 1;
  endfunction
endpackage

// File: rtl/tb_port_fsm.sv
// tb_port_fsm: one bus channel's request capture, wait timer and ack; TB_RANDOM_WAIT_EN adds LFSR wait jitter
module tb_port_fsm import tb_pkg::*; #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
`ifdef TB_RANDOM_WAIT_EN
  parameter int PORT_IDX = 0,
`endif
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic                    ack,
  output logic                    cap_we,
  output logic [ADDR_WIDTH-1:0]   cap_addr,
  output logic [DATA_WIDTH-1:0]   cap_wdata,
  output logic [DATA_WIDTH/8-1:0] cap_be
);
  port_state_t state, state_nx;
  logic [31:0] cnt, cnt_nx, wait_len;
  logic accept;
  assign accept = state == IDLE && req;
`ifdef TB_RANDOM_WAIT_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= LFSR_SEED ^ 16'(PORT_IDX);
    else if (accept) lfsr <= lfsr_step(lfsr);
  assign wait_len = 32'(WAIT_CYCLES) + 32'(lfsr[1:0]);
`else
  assign wait_len = 32'(WAIT_CYCLES);
`endif
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (accept) begin
      state_nx = wait_len != 0 ? WAIT : RESP;
      cnt_nx = wait_len;
    end else if (state == WAIT) begin
      cnt_nx = cnt - 32'd1;
      state_nx = cnt == 32'd1 ? RESP : WAIT;
    end else if (state == RESP) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      cap_we <= 1'b0;
      cap_addr <= '0;
      cap_wdata <= '0;
      cap_be <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (accept) begin
        cap_we <= we;
        cap_addr <= addr;
        cap_wdata <= wdata;
        cap_be <= be;
      end
    end
  assign ack = state == RESP;
endmodule

// File: rtl/tb_mem_responder.sv
// tb_mem_responder: multi-port simulation memory with test-exit register and watchdog; TB_RANDOM_WAIT_EN enables random wait states
module tb_mem_responder import tb_pkg::*; #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int NUM_PORTS = 2,
  parameter int WAIT_CYCLES = 0,
  parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR = DEFAULT_CTRL_ADDR[ADDR_WIDTH-1:0],
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NUM_PORTS-1:0]              we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata,
  output logic [NUM_PORTS-1:0]              ack,
  output logic                              done,
  output logic                              pass,
  output logic [DATA_WIDTH-1:0]             exit_code,
  output logic                              timeout,
  output logic [31:0]                       cycle_count
);
  localparam int BW = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [NUM_PORTS-1:0] cap_we, is_ctrl;
  logic [ADDR_WIDTH-1:0] cap_addr [NUM_PORTS];
  logic [DATA_WIDTH-1:0] cap_wdata [NUM_PORTS];
  logic [BW-1:0] cap_be [NUM_PORTS];
  logic ctrl_hit, wd_fire;
  logic [DATA_WIDTH-1:0] ctrl_data;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [DATA_WIDTH-1:0] rd, rdata_q;
    tb_port_fsm #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
`ifdef TB_RANDOM_WAIT_EN
      .PORT_IDX(p),
`endif
      .WAIT_CYCLES(WAIT_CYCLES)
    ) u_fsm (
      .clk(clk),
      .rst_n(rst_n),
      .req(req[p]),
      .we(we[p]),
      .addr(addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .wdata(wdata[p*DATA_WIDTH +: DATA_WIDTH]),
      .be(be[p*BW +: BW]),
      .ack(ack[p]),
      .cap_we(cap_we[p]),
      .cap_addr(cap_addr[p]),
      .cap_wdata(cap_wdata[p]),
      .cap_be(cap_be[p])
    );
    assign is_ctrl[p] = cap_addr[p] == CTRL_ADDR;
    assign rd = is_ctrl[p] ? DATA_WIDTH'(cycle_count) : mem[cap_addr[p][DEPTH_LOG2-1:0]];
    assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = ack[p] ? rd : rdata_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rdata_q <= '0;
      else if (ack[p]) rdata_q <= rd;
  end
  // later ports overwrite earlier ones, so the highest index wins each byte lane
  always_ff @(posedge clk)
    for (int p = 0; p < NUM_PORTS; p++)
      for (int b = 0; b < BW; b++)
        if (ack[p] && cap_we[p] && !is_ctrl[p] && cap_be[p][b])
          mem[cap_addr[p][DEPTH_LOG2-1:0]][b*8 +: 8] <= cap_wdata[p][b*8 +: 8];
  always_comb begin
    ctrl_hit = 1'b0;
    ctrl_data = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (ack[p] && cap_we[p] && is_ctrl[p]) begin
        ctrl_hit = 1'b1;
        ctrl_data = cap_wdata[p];
      end
  end
  assign wd_fire = cycle_count == 32'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done <= 1'b0;
      pass <= 1'b0;
      timeout <= 1'b0;
      exit_code <= '0;
      cycle_count <= '0;
    end else if (!done) begin
      if (ctrl_hit) begin
        done <= 1'b1;
        pass <= ctrl_data == EXIT_PASS[DATA_WIDTH-1:0];
        exit_code <= ctrl_data;
      end else if (wd_fire) begin
        done <= 1'b1;
        timeout <= 1'b1;
        pass <= 1'b0;
        exit_code <= EXIT_TIMEOUT[DATA_WIDTH-1:0];
      end else if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
    end
endmodule

// File: tb/tb_tb_mem_responder.sv
// tb_tb_mem_responder: directed table and sequence checks for tb_mem_responder
module tb_tb_mem_responder;
  localparam logic [29:0] CTRL = '1;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] req_a = '0, we_a = '0, ack_a;
  logic [59:0] addr_a = '0;
  logic [63:0] wdata_a = '0, rdata_a;
  logic [7:0] be_a = '0;
  logic done_a, pass_a, timeout_a;
  logic [31:0] exit_a, cc_a;

  logic [1:0] req_t = '0, we_t = '0, ack_t;
  logic [59:0] addr_t = '0;
  logic [63:0] wdata_t = '0, rdata_t;
  logic [7:0] be_t = '0;
  logic done_t, pass_t, timeout_t;
  logic [31:0] exit_t, cc_t;

  tb_mem_responder #(.WAIT_CYCLES(2), .TIMEOUT(1000)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .be(be_a), .rdata(rdata_a), .ack(ack_a), .done(done_a), .pass(pass_a),
    .exit_code(exit_a), .timeout(timeout_a), .cycle_count(cc_a));

  tb_mem_responder #(.WAIT_CYCLES(0), .TIMEOUT(20)) dut_t (
    .clk(clk), .rst_n(rst_n), .req(req_t), .we(we_t), .addr(addr_t), .wdata(wdata_t),
    .be(be_t), .rdata(rdata_t), .ack(ack_t), .done(done_t), .pass(pass_t),
    .exit_code(exit_t), .timeout(timeout_t), .cycle_count(cc_t));

  typedef struct {
    logic        p;
    logic        w;
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [13];

  int checks = 0, failures = 0;
  logic [31:0] r0, r1;
  int t0, t1, acks;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // drives the enabled ports together; t = negedges until ack (0 if it never came)
  task automatic run(input logic [1:0] en, input logic [1:0] w,
                     input logic [29:0] a0, input logic [29:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [3:0] b0, input logic [3:0] b1,
                     output logic [31:0] q0, output logic [31:0] q1,
                     output int l0, output int l1);
    @(negedge clk);
    req_a = en;
    we_a = w;
    addr_a = {a1, a0};
    wdata_a = {d1, d0};
    be_a = {b1, b0};
    l0 = 0;
    l1 = 0;
    q0 = '0;
    q1 = '0;
    for (int n = 1; n <= 20 && ((en[0] && l0 == 0) || (en[1] && l1 == 0)); n++) begin
      @(negedge clk);
      if (ack_a[0] && l0 == 0) begin
        l0 = n;
        q0 = rdata_a[31:0];
        req_a[0] = 1'b0;
      end
      if (ack_a[1] && l1 == 0) begin
        l1 = n;
        q1 = rdata_a[63:32];
        req_a[1] = 1'b0;
      end
    end
    req_a = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 30'd5,    32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 30'd5,    32'h0,        4'hF, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b1, 30'd7,    32'h0,        4'hF, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 30'd7,    32'h11223344, 4'h5, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 30'd7,    32'h0,        4'hF, 32'h00220044};
    tbl[5]  = '{1'b1, 1'b1, 30'd7,    32'hAABBCCDD, 4'h0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 30'd7,    32'h0,        4'hF, 32'h00220044};
    tbl[7]  = '{1'b1, 1'b1, 30'd4101, 32'hCAFEF00D, 4'hF, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 30'd5,    32'h0,        4'hF, 32'hCAFEF00D};
    tbl[9]  = '{1'b0, 1'b1, 30'd9,    32'h01020304, 4'hF, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 30'd9,    32'h0,        4'hF, 32'h01020304};
    tbl[11] = '{1'b0, 1'b1, 30'd3,    32'h12345678, 4'hF, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 30'd3,    32'h0,        4'hF, 32'h12345678};

    // watchdog on the TIMEOUT=20 instance
    do_reset();
    check("rst_done", done_t, 0);
    check("rst_cc", cc_t, 0);
    check("rst_exit", exit_t, 0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("wd_cc19", cc_t, 19);
    check("wd_pre_done", done_t, 0);
    @(posedge clk);
    @(negedge clk);
    check("wd_done", done_t, 1);
    check("wd_timeout", timeout_t, 1);
    check("wd_pass", pass_t, 0);
    check("wd_exit", exit_t, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    check("wd_cc_frozen", cc_t, 19);

    // control write lands in the watchdog cycle and wins
    do_reset();
    repeat (18) @(posedge clk);
    @(negedge clk);
    req_t = 2'b01;
    we_t = 2'b01;
    addr_t = {30'd0, CTRL};
    wdata_t = {32'd0, 32'd7};
    be_t = 8'h0F;
    @(negedge clk);
    check("pri_ack", ack_t[0], 1);
    check("pri_cc", cc_t, 19);
    req_t = '0;
    @(negedge clk);
    check("pri_done", done_t, 1);
    check("pri_timeout", timeout_t, 0);
    check("pri_pass", pass_t, 0);
    check("pri_exit", exit_t, 7);

    // single-port vector table on the WAIT_CYCLES=2 instance
    do_reset();
    check("rst_rdata", rdata_a, 0);
    check("rst_ack", ack_a, 0);
    for (int i = 0; i < 13; i++) begin
      run(tbl[i].p ? 2'b10 : 2'b01, {tbl[i].w, tbl[i].w}, tbl[i].a, tbl[i].a,
          tbl[i].d, tbl[i].d, tbl[i].b, tbl[i].b, r0, r1, t0, t1);
      check($sformatf("row%0d_latency", i), tbl[i].p ? t1 : t0, 3);
      if (!tbl[i].w) check($sformatf("row%0d_rdata", i), tbl[i].p ? r1 : r0, tbl[i].exp);
      @(negedge clk);
      check($sformatf("row%0d_ack_one", i), ack_a, 0);
    end

    // concurrent access to addr 9
    run(2'b11, 2'b10, 30'd9, 30'd9, 32'h0, 32'h0F0F0F0F, 4'hF, 4'hF, r0, r1, t0, t1);
    check("rw_lat0", t0, 3);
    check("rw_lat1", t1, 3);
    check("rw_old_data", r0, 32'h01020304);
    run(2'b11, 2'b11, 30'd9, 30'd9, 32'hAAAAAAAA, 32'h55555555, 4'hF, 4'hF, r0, r1, t0, t1);
    run(2'b01, 2'b00, 30'd9, 30'd9, 32'h0, 32'h0, 4'hF, 4'hF, r0, r1, t0, t1);
    check("ww_full", r0, 32'h55555555);
    run(2'b11, 2'b11, 30'd9, 30'd9, 32'hAAAAAAAA, 32'h55555555, 4'hF, 4'h3, r0, r1, t0, t1);
    run(2'b10, 2'b00, 30'd9, 30'd9, 32'h0, 32'h0, 4'hF, 4'hF, r0, r1, t0, t1);
    check("ww_lanes", r1, 32'hAAAA5555);

    // exit register written at cycle 50
    do_reset();
    repeat (47) @(posedge clk);
    run(2'b01, 2'b01, CTRL, 30'd0, 32'd0, 32'd0, 4'hF, 4'hF, r0, r1, t0, t1);
    check("ctl_lat", t0, 3);
    run(2'b01, 2'b01, CTRL, 30'd0, 32'd3, 32'd0, 4'hF, 4'hF, r0, r1, t0, t1);
    check("ctl_done", done_a, 1);
    check("ctl_pass", pass_a, 1);
    check("ctl_exit", exit_a, 0);
    check("ctl_timeout", timeout_a, 0);
    check("ctl_cc", cc_a, 50);
    run(2'b01, 2'b00, CTRL, 30'd0, 32'd0, 32'd0, 4'hF, 4'hF, r0, r1, t0, t1);
    check("ctl_read", r0, 50);

    // reset during the wait states of a write to addr 3
    @(negedge clk);
    req_a = 2'b01;
    we_a = 2'b01;
    addr_a = {30'd0, 30'd3};
    wdata_a = {32'd0, 32'hFFFFFFFF};
    be_a = 8'h0F;
    @(negedge clk);
    check("mid_ack_wait", ack_a, 0);
    rst_n = 1'b0;
    req_a = '0;
    #1;
    check("mid_done", done_a, 0);
    check("mid_pass", pass_a, 0);
    check("mid_exit", exit_a, 0);
    check("mid_cc", cc_a, 0);
    check("mid_rdata", rdata_a, 0);
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack_a != 0) acks++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ack_a != 0) acks++;
    end
    check("mid_no_ack", acks, 0);
    run(2'b01, 2'b00, 30'd3, 30'd0, 32'd0, 32'd0, 4'hF, 4'hF, r0, r1, t0, t1);
    check("mid_addr3", r0, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tb_mem_responder.md
Name: tb_mem_responder

Overview:
- Parametrised simulation-side memory and test-control responder. It replaces the empty top-level bench shell as the thing the CPU core talks to.
- Serves NUM_PORTS independent req/ack bus channels (instruction and data fetch) from one shared word array, with configurable wait states.
- Provides a memory-mapped test-exit register, a free-running cycle counter and a watchdog, so any program can end the run with pass or fail.

Parameters:
- ADDR_WIDTH, 30: word address width per port.
- DATA_WIDTH, 32: data word width; must be a multiple of 8.
- DEPTH_LOG2, 12: log2 of the number of backing-store words.
- NUM_PORTS, 2: number of independent bus channels.
- WAIT_CYCLES, 0: fixed wait states inserted before every ack.
- CTRL_ADDR, all ones (ADDR_WIDTH bits): word address of the test-control register.
- TIMEOUT, 100000: watchdog limit in cycles.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_PORTS  per-port request; held high until ack.
- we  in  NUM_PORTS  per-port write enable; sampled with req.
- addr  in  NUM_PORTS*ADDR_WIDTH  per-port word address, port p in slice p.
- wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- be  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables.
- rdata  out  NUM_PORTS*DATA_WIDTH  per-port read data; valid in the ack cycle.
- ack  out  NUM_PORTS  per-port one-cycle completion pulse.
- done  out  1  sticky: test finished.
- pass  out  1  sticky: exit code was zero; qualified by done.
- exit_code  out  DATA_WIDTH  sticky: value written to CTRL_ADDR.
- timeout  out  1  sticky: watchdog fired.
- cycle_count  out  32  cycles elapsed since reset.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled by the environment):
  - ack=0, rdata=0, done=0, pass=0, timeout=0, exit_code=0, cycle_count=0.
  - All port FSMs go to IDLE.
  - The memory array is not reset.
- Per-port FSM states: IDLE, WAIT, RESP.
  - IDLE: on req=1, capture we, addr, wdata and be. Go to WAIT if the wait count is >0, else RESP.
  - WAIT: decrement the wait counter; go to RESP when it reaches 0.
  - RESP: ack=1 for exactly one cycle, perform the access, return to IDLE.
  - The next request is accepted from IDLE one cycle later, so sustained throughput is one access per WAIT_CYCLES+2 cycles.
- Latency: ack asserts WAIT_CYCLES+1 cycles after the rising clock edge that samples req in IDLE.
- A port ignores req while not IDLE. Once captured, a transaction completes even if req drops early.
- Address mapping:
  - Captured addr equal to CTRL_ADDR selects the control register.
  - Any other address uses addr[DEPTH_LOG2-1:0], so addresses wrap modulo the depth.
- Reads: rdata holds the array word in the ack cycle and keeps its last value otherwise. Reads of CTRL_ADDR return cycle_count, zero-extended to DATA_WIDTH.
- Writes: byte-lane masked by be. A write with be=0 acks but changes nothing.
- Simultaneous ack on several ports:
  - Reads see pre-write (old) data.
  - Writes to the same word commit in ascending port order, so the highest index wins per byte lane.
- Control register write with done=0:
  - done=1, exit_code=wdata, pass=(wdata==0).
  - Control writes while done=1 are acked and ignored.
  - If two ports write the control register in the same cycle, the highest port index wins.
- Watchdog:
  - cycle_count increments every cycle while done=0, saturates at 2^32-1, and freezes once done=1.
  - When cycle_count==TIMEOUT-1 and done=0: timeout=1, done=1, pass=0, exit_code=all ones.
  - A control write in that same cycle takes priority; timeout then stays 0.
- Reset mid-transaction: the FSM is forced to IDLE and no pending write commits.

Optional Feature:
- Macro TB_RANDOM_WAIT_EN.
- Defined:
  - Each port owns a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seeded with 16'hACE1 XOR port index, that steps once per accepted request.
  - Its low 2 bits add 0 to 3 extra wait cycles on top of WAIT_CYCLES.
  - The sequence is deterministic after reset.
- Undefined: no LFSR is built and the wait is exactly WAIT_CYCLES.

Decomposition:
- Package tb_pkg:
  - port state enum (IDLE, WAIT, RESP)
  - default CTRL_ADDR
  - EXIT_PASS=0 and EXIT_TIMEOUT=all ones
  - LFSR seed and tap constants
- Sub-module tb_port_fsm, one instance per port: request capture, wait counter, optional LFSR, ack generation.
- The top level owns the shared array, write ordering, control register and watchdog.

Test Plan:
1. WAIT_CYCLES=2, port0 read of addr 5 preloaded with 32'hDEADBEEF -> ack exactly 3 cycles after req sampled, rdata=32'hDEADBEEF.
2. Port0 write 32'h11223344 with be=4'b0101 to addr 7 (old value 0), then read back -> 32'h00220044.
3. Both ports write addr 9 in the same cycle (p0 32'hAAAAAAAA, p1 32'h55555555), be all ones -> array holds 32'h55555555; a concurrent port0 read of addr 9 returns the old value.
4. Write 0 to CTRL_ADDR at cycle 50, then write 3 -> done=1, pass=1, exit_code=0, cycle_count frozen at 50.
5. TIMEOUT=20, no control write -> at cycle 19 done=1, timeout=1, pass=0, exit_code=32'hFFFFFFFF.
6. Assert rst_n=0 during a WAIT state of a write to addr 3 -> ack never pulses, addr 3 unchanged, all outputs back to their reset values.
